// File: rtl/krypton_vga_out.sv
// Parametrised VGA timing generator and latency-aligned, blanked RGB output stage.
// Optional colour-bar generator is enabled by defining KRYPTON_VGA_TESTBARS_EN.
module krypton_vga_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CBITS    = 3,
  parameter int PIPE_LAT = 1,
  parameter int CNT_W    = 10
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [3*CBITS-1:0] i_color,
  input  logic               i_testMode,
  output logic [CNT_W-1:0]   o_HCounter,
  output logic [CNT_W-1:0]   o_VCounter,
  output logic               o_frameStart,
  output logic               o_lineStart,
  output logic               o_activeVideo,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic [CBITS-1:0]   o_Red,
  output logic [CBITS-1:0]   o_Grn,
  output logic [CBITS-1:0]   o_Blu
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // run_reg holds the counters at (0,0) for the first edge after reset so that
  // the strobes, which decode the next count, can flag that first (0,0) cycle.
  logic             run_reg;
  logic [CNT_W-1:0] h_reg, v_reg;
  logic [CNT_W-1:0] h_next, v_next;
  logic             frame_start_reg, line_start_reg;

  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (run_reg) begin
      if (h_reg == H_LAST) begin
        h_next = '0;
        v_next = (v_reg == V_LAST) ? '0 : v_reg + 1'b1;
      end else begin
        h_next = h_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      run_reg         <= 1'b0;
      h_reg           <= '0;
      v_reg           <= '0;
      frame_start_reg <= 1'b0;
      line_start_reg  <= 1'b0;
    end else begin
      run_reg         <= 1'b1;
      h_reg           <= h_next;
      v_reg           <= v_next;
      frame_start_reg <= (h_next == '0) && (v_next == '0);
      line_start_reg  <= (h_next == '0);
    end
  end

  assign o_HCounter   = h_reg;
  assign o_VCounter   = v_reg;
  assign o_frameStart = frame_start_reg;
  assign o_lineStart  = line_start_reg;

  // Raw timing decode, packed as {active, hs, vs}.
  logic       active_raw, hs_raw, vs_raw;
  logic [2:0] timing_raw;

  assign active_raw = (h_reg < H_ACT) && (v_reg < V_ACT);
  assign hs_raw     = (h_reg >= H_HS_START) && (h_reg < H_HS_END);
  assign vs_raw     = (v_reg >= V_VS_START) && (v_reg < V_VS_END);
  assign timing_raw = {active_raw, hs_raw, vs_raw};

  // tline[n] carries the decode of the counters from n cycles earlier.
  logic [2:0] tline [1:PIPE_LAT+1];

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 1; i <= PIPE_LAT + 1; i++) begin
        tline[i] <= 3'b000;
      end
    end else if (run_reg) begin
      tline[1] <= timing_raw;
      for (int i = 2; i <= PIPE_LAT + 1; i++) begin
        tline[i] <= tline[i-1];
      end
    end
  end

  // Active flag for the pixel whose colour is currently on i_color.
  logic gate_active;

  generate
    if (PIPE_LAT == 0) begin : g_gate_raw
      assign gate_active = active_raw;
    end else begin : g_gate_line
      assign gate_active = tline[PIPE_LAT][2];
    end
  endgenerate

  logic [3*CBITS-1:0] color_src;

`ifdef KRYPTON_VGA_TESTBARS_EN
  localparam int BAR_W = H_ACTIVE / 8;

  genvar gi;
  logic [6:0] bar_past;
  logic [2:0] bar_idx;
  logic [3:0] bar_raw;
  logic [3:0] bar_sel;

  generate
    for (gi = 1; gi < 8; gi++) begin : g_bar_edge
      assign bar_past[gi-1] = (h_reg >= CNT_W'(gi * BAR_W));
    end
  endgenerate

  always_comb begin
    bar_idx = 3'd0;
    for (int k = 0; k < 7; k++) begin
      bar_idx = bar_idx + {2'b00, bar_past[k]};
    end
  end

  // {mode, kk}: kk = 7 - bar index selects the R/G/B enables.
  assign bar_raw = {i_testMode, 3'd7 - bar_idx};

  generate
    if (PIPE_LAT == 0) begin : g_bar_direct
      assign bar_sel = bar_raw;
    end else begin : g_bar_line
      logic [3:0] bline [1:PIPE_LAT];
      always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
          for (int i = 1; i <= PIPE_LAT; i++) begin
            bline[i] <= 4'b0000;
          end
        end else if (run_reg) begin
          bline[1] <= bar_raw;
          for (int i = 2; i <= PIPE_LAT; i++) begin
            bline[i] <= bline[i-1];
          end
        end
      end
      assign bar_sel = bline[PIPE_LAT];
    end
  endgenerate

  assign color_src = bar_sel[3] ? {{CBITS{bar_sel[2]}}, {CBITS{bar_sel[1]}}, {CBITS{bar_sel[0]}}}
                                : i_color;
`else
  logic unused_test_mode;

  assign unused_test_mode = i_testMode;
  assign color_src        = i_color;
`endif

  logic [3*CBITS-1:0] rgb_reg;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rgb_reg <= '0;
    end else if (run_reg) begin
      rgb_reg <= gate_active ? color_src : '0;
    end
  end

  assign o_Red = rgb_reg[3*CBITS-1:2*CBITS];
  assign o_Grn = rgb_reg[2*CBITS-1:CBITS];
  assign o_Blu = rgb_reg[CBITS-1:0];

  assign o_activeVideo = tline[PIPE_LAT+1][2];
  assign o_HSync       = ~(tline[PIPE_LAT+1][1] ^ SYNC_POL);
  assign o_VSync       = ~(tline[PIPE_LAT+1][0] ^ SYNC_POL);

endmodule

// File: tb/tb_krypton_vga_out.sv
// Directed bench: a default-sized instance plus a small, deep-pipeline, active-high instance.
module tb_krypton_vga_out;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [8:0] color1 = 9'h000;
  logic       tm1 = 1'b0;
  logic [9:0] h1, v1;
  logic       fs1, ls1, act1, hs1, vs1;
  logic [2:0] r1, g1, b1;

  logic [11:0] color2 = 12'hA5C;
  logic        tm2 = 1'b1;
  logic [9:0]  h2, v2;
  logic        fs2, ls2, act2, hs2, vs2;
  logic [3:0]  r2, g2, b2;

  krypton_vga_out dut (
    .i_Clk(clk), .i_Rst(rst), .i_color(color1), .i_testMode(tm1),
    .o_HCounter(h1), .o_VCounter(v1), .o_frameStart(fs1), .o_lineStart(ls1),
    .o_activeVideo(act1), .o_HSync(hs1), .o_VSync(vs1),
    .o_Red(r1), .o_Grn(g1), .o_Blu(b1)
  );

  // 24 x 8 raster, 4-cycle latency, active-high syncs, 4-bit channels.
  krypton_vga_out #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .CBITS(4), .PIPE_LAT(3), .CNT_W(10)
  ) dut2 (
    .i_Clk(clk), .i_Rst(rst), .i_color(color2), .i_testMode(tm2),
    .o_HCounter(h2), .o_VCounter(v2), .o_frameStart(fs2), .o_lineStart(ls2),
    .o_activeVideo(act2), .o_HSync(hs2), .o_VSync(vs2),
    .o_Red(r2), .o_Grn(g2), .o_Blu(b2)
  );

`ifdef KRYPTON_VGA_TESTBARS_EN
  localparam logic [11:0] P0  = 12'hFFF;
  localparam logic [11:0] P2  = 12'hFF0;
  localparam logic [11:0] P15 = 12'h000;
`else
  localparam logic [11:0] P0  = 12'hA5C;
  localparam logic [11:0] P2  = 12'hA5C;
  localparam logic [11:0] P15 = 12'hA5C;
`endif

  int passed = 0;
  int total  = 0;
  int k      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // k counts rising edges since reset release; sampling happens on the falling edge.
  task automatic go(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_h", h1, 0);
    chk("rst_v", v1, 0);
    chk("rst_fs", fs1, 0);
    chk("rst_act", act1, 0);
    chk("rst_rgb", {r1, g1, b1}, 0);
    chk("rst_hs", hs1, 1);
    chk("rst_vs", vs1, 1);
    chk("rst2_hs", hs2, 0);
    chk("rst2_vs", vs2, 0);
    rst = 1'b0;
    k = 0;

    go(1);
    chk("k1_h", h1, 0);
    chk("k1_v", v1, 0);
    chk("k1_fs", fs1, 1);
    chk("k1_ls", ls1, 1);
    chk("k1_act", act1, 0);
    chk("k1_hs", hs1, 1);
    chk("k1_fs2", fs2, 1);

    go(2);
    chk("k2_h", h1, 1);
    chk("k2_fs", fs1, 0);
    chk("k2_ls", ls1, 0);
    color1 = 9'h1FF;
    go(3);
    chk("pix0_rgb", {r1, g1, b1}, 9'h1FF);
    chk("pix0_act", act1, 1);
    color1 = 9'h000;
    go(4);
    chk("pix1_rgb", {r1, g1, b1}, 0);
    chk("pix1_act", act1, 1);
    chk("d2_act_early", act2, 0);

    go(5);
    chk("d2_act_rise", act2, 1);
    chk("d2_pix0", {r2, g2, b2}, P0);
    go(7);
    chk("d2_pix2", {r2, g2, b2}, P2);
    go(20);
    chk("d2_pix15_act", act2, 1);
    chk("d2_pix15", {r2, g2, b2}, P15);
    go(21);
    chk("d2_pix16_act", act2, 0);
    chk("d2_pix16", {r2, g2, b2}, 0);
    go(22);
    chk("d2_hs_pre", hs2, 0);
    go(23);
    chk("d2_hs_first", hs2, 1);
    go(25);
    chk("d2_hs_last", hs2, 1);
    chk("d2_ls", ls2, 1);
    chk("d2_h_wrap", h2, 0);
    chk("d2_v_inc", v2, 1);
    go(26);
    chk("d2_hs_post", hs2, 0);

    go(124);
    chk("d2_vs_pre", vs2, 0);
    go(125);
    chk("d2_vs_first", vs2, 1);
    go(172);
    chk("d2_vs_last", vs2, 1);
    go(173);
    chk("d2_vs_post", vs2, 0);
    go(192);
    chk("d2_fs_pre", fs2, 0);
    go(193);
    chk("d2_fs_period", fs2, 1);
    chk("d2_v_wrap", v2, 0);
    chk("d2_h_wrap2", h2, 0);

    go(640);
    color1 = 9'h1FF;
    go(642);
    chk("pix639_rgb", {r1, g1, b1}, 9'h1FF);
    chk("pix639_act", act1, 1);
    go(643);
    chk("pix640_rgb", {r1, g1, b1}, 0);
    chk("pix640_act", act1, 0);
    go(658);
    chk("hs_pre", hs1, 1);
    go(659);
    chk("hs_first", hs1, 0);
    go(702);
    chk("h700_rgb", {r1, g1, b1}, 0);
    chk("h700_act", act1, 0);
    go(754);
    chk("hs_last", hs1, 0);
    go(755);
    chk("hs_post", hs1, 1);
    chk("vs_line0", vs1, 1);
    go(800);
    chk("ls_pre", ls1, 0);
    go(801);
    chk("ls_period", ls1, 1);
    chk("line1_h", h1, 0);
    chk("line1_v", v1, 1);
    go(820);
    chk("line1_rgb", {r1, g1, b1}, 9'h1FF);
    chk("line1_h_pos", h1, 19);

    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rgb", {r1, g1, b1}, 0);
    chk("mid_rst_act", act1, 0);
    chk("mid_rst_hs", hs1, 1);
    chk("mid_rst_h", h1, 0);
    chk("mid_rst_v", v1, 0);
    chk("mid_rst_ls", ls1, 0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    go(1);
    chk("restart_fs", fs1, 1);
    chk("restart_h", h1, 0);
    chk("restart_rgb", {r1, g1, b1}, 0);
    go(2);
    chk("restart_h1", h1, 1);
    chk("restart_fs_drop", fs1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/krypton_vga_out.md
Name: krypton_vga_out

Overview:
Parametrised VGA timing and output stage, the next generation of the fixed 640x480, 3:3:3 top-level sync and colour path. It generates the H/V pixel counters for the video source and accepts colour back after a configurable pipeline latency. It delays sync and blanking to match that latency, and drives registered, blanked RGB pins of configurable depth. It also provides frame and line start strobes.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, 0 = active-low syncs, 1 = active-high syncs
CBITS, 3, bits per colour channel
PIPE_LAT, 1, cycles from counter output to i_color valid for that pixel (0..15)
CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
i_Clk  in  1  pixel clock
i_Rst  in  1  reset, asynchronous, active-high
i_color  in  3*CBITS  pixel colour {R,G,B}, MSB-first, valid PIPE_LAT cycles after its counters
i_testMode  in  1  select built-in colour bars (see Optional Feature)
o_HCounter  out  CNT_W  current horizontal position
o_VCounter  out  CNT_W  current line
o_frameStart  out  1  one-cycle strobe while counters = (0,0)
o_lineStart  out  1  one-cycle strobe while o_HCounter = 0
o_activeVideo  out  1  latency-aligned visible-region flag
o_HSync  out  1  latency-aligned horizontal sync
o_VSync  out  1  latency-aligned vertical sync
o_Red, o_Grn, o_Blu  out  CBITS each  blanked colour pins

Behaviour:
- Timing totals: H_TOTAL = sum of the H parameters = 800; V_TOTAL = sum of the V parameters = 525.
- H counter: 0..H_TOTAL-1, wraps to 0.
- V counter: increments only on the H wrap; wraps 0 after V_TOTAL-1 on the same edge.
- Raw decode from the counters:
  - active = H<H_ACTIVE && V<V_ACTIVE
  - hs = H in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs = V in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
- Strobes: o_frameStart and o_lineStart are registered decodes of the next counter value. They are high exactly in the cycle the counters show (0,0) and H=0 respectively.
- Delay line: active, hs and vs pass through a PIPE_LAT+1 stage register line. The pins reflect the counters from PIPE_LAT+1 cycles earlier.
- Sync pins: o_HSync = hs_d XNOR SYNC_POL, i.e. asserted level = SYNC_POL. o_VSync is formed the same way.
- Colour register: the colour is registered once. If the delayed active flag at stage PIPE_LAT is 1, the pins take the i_color slices; otherwise they take 0. Colour therefore lands on the same edge as its aligned sync and active flag.
- PIPE_LAT=0: i_color is sampled in the same cycle as its counters; total latency is 1.
- Reset (async assert; release is synchronised by the caller):
  - counters = 0
  - delay line cleared to inactive / deasserted
  - colour pins = 0; o_activeVideo = 0; strobes = 0
  - syncs at their deasserted level (1 for SYNC_POL=0)
  - A reset mid-frame takes effect immediately, with no partial-line completion.
- First cycle after reset release: counters (0,0), o_frameStart = 1. First aligned active pixel appears PIPE_LAT+1 cycles later.
- No backpressure: the block free-runs and never stalls.

Optional Feature:
KRYPTON_VGA_TESTBARS_EN
- Defined: while i_testMode=1, an internal generator replaces i_color with 8 vertical colour bars, each H_ACTIVE/8 pixels wide (integer, computed at elaboration).
  - Bar k uses kk = 7-k. Red = all-ones if kk[2] else 0; Grn follows kk[1]; Blu follows kk[0]. Bar 0 is white, bar 7 is black.
  - The generator is delayed PIPE_LAT cycles so its alignment is identical to i_color.
  - i_testMode changes take effect on the pins PIPE_LAT+1 cycles later.
- Undefined: i_testMode is ignored and no bar logic is synthesised.

Test Plan:
1. Hold i_Rst=1, then release → all colour pins 0, o_HSync=o_VSync=1, counters (0,0), o_frameStart=1 in the first cycle; o_lineStart repeats every 800 cycles.
2. Defaults, PIPE_LAT=1 → o_HSync low for exactly 96 cycles, beginning 2 cycles after o_HCounter=656. o_VSync low for 1600 cycles, beginning 2 cycles after counters reach (0,490). o_frameStart period = 420000 cycles.
3. Drive i_color=9'h1FF only in the cycle 1 after counters (0,0); drive 9'h1FF constantly during H=700 → pins R=G=B=7 for exactly one cycle at 2 cycles after (0,0), with o_activeVideo=1. Pins stay 0 throughout the H=700 blanking.
4. Assert i_Rst at counters (300,200) while pins are non-zero → same-cycle asynchronous clear: pins 0, syncs 1, counters 0. Frame restarts with o_frameStart after release.
5. SYNC_POL=1, CBITS=4, PIPE_LAT=3, i_color=12'hA5C held → syncs idle low and pulse high. Visible pins read R=A, G=5, B=C. o_activeVideo rises 4 cycles after the counters enter (0,0).
6. KRYPTON_VGA_TESTBARS_EN defined, i_testMode=1 → on line 0: pixels 0..79 = {7,7,7}, pixels 80..159 = {7,7,0}, pixels 560..639 = {0,0,0}. With i_testMode=0, pins follow i_color.
